// File: rtl/code_decoder_pkg.sv
// Shared constants for the code decoder: state encoding, bus widths and the
// code-to-line decode helper.
package code_decoder_pkg;

    localparam int LINE_W = 4;
    localparam int CODE_W = 2;
    localparam int ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_DRIVE = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP   = 2'd2;

    function automatic logic [LINE_W-1:0] decode_code(input logic [CODE_W-1:0] c);
        logic [LINE_W-1:0] onehot;
        onehot    = '0;
        onehot[c] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Load/decrement down-counter shared by the DRIVE and GAP phases; it saturates
// at zero and reports done while the count is zero.
module pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/code_decoder.sv
// Two-bit code to one-hot pulse decoder with a fixed pulse length and a
// post-pulse guard gap. Optional parity check enabled by CODE_DECODER_PARITY_EN.
module code_decoder
    import code_decoder_pkg::*;
#(
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
`ifdef CODE_DECODER_PARITY_EN
    input  logic              code_par,
    output logic              par_err,
`endif
    output logic              code_ready,
    output logic [LINE_W-1:0] line,
    output logic              busy
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    // Phases last load+1 cycles, since done is seen in the cycle the count reaches zero.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  next_state;
    logic             accept;
    logic             par_ok;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_done;

`ifdef CODE_DECODER_PARITY_EN
    assign par_ok = ~(^{code, code_par});
`else
    assign par_ok = 1'b1;
`endif

    // code_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign accept = code_valid & code_ready;

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (accept && par_ok) begin
                    next_state  = ST_DRIVE;
                    timer_load  = 1'b1;
                    timer_value = PULSE_LOAD;
                end
            end
            ST_DRIVE: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (GAP_LEN > 0) begin
                        next_state  = ST_GAP;
                        timer_value = GAP_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (timer_done) begin
                    next_state = ST_IDLE;
                    timer_load = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                timer_load = 1'b1;
            end
        endcase
    end

    pulse_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            code_ready <= 1'b0;
            line       <= '0;
        end else begin
            state      <= next_state;
            code_ready <= (next_state == ST_IDLE);
            if (state == ST_IDLE && next_state == ST_DRIVE) begin
                line <= decode_code(code);
            end else if (next_state != ST_DRIVE) begin
                line <= '0;
            end
        end
    end

`ifdef CODE_DECODER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= accept & ~par_ok;
        end
    end
`endif

    assign busy = (state != ST_IDLE);

endmodule
